// File: rtl/sysid_info_slave.sv
// System-ID / timestamp / uptime Avalon-MM slave with scratch registers.
// Zero wait states, fixed read latency of one cycle.
module sysid_info_slave #(
  parameter logic [31:0] SYSTEM_ID   = 32'd7,
  parameter logic [31:0] TIMESTAMP   = 32'h5284_E192,
  parameter int unsigned NUM_SCRATCH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [63:0] r_counter;
  logic [31:0] r_snap;
  logic        r_en;
  logic [31:0] r_scratch [NUM_SCRATCH];
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic        w_ctrl_wr;
  logic        w_clr;
  logic        w_scr_hit;
  logic [31:0] w_rdata;

  assign w_ctrl_wr = write && (address == 4'd4) && byteenable[0];
  assign w_clr     = w_ctrl_wr && writedata[1];
  assign w_scr_hit = address[3] && ({29'd0, address[2:0]} < NUM_SCRATCH);

  always_comb begin
    w_rdata = '0;
    case (address)
      4'd0:    w_rdata = SYSTEM_ID;
      4'd1:    w_rdata = TIMESTAMP;
      4'd2:    w_rdata = r_counter[31:0];
      // High word comes from the snapshot so a LO-then-HI pair is coherent.
      4'd3:    w_rdata = r_snap;
      4'd4:    w_rdata = {31'd0, r_en};
      default: begin
        for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
          if (w_scr_hit && (address[2:0] == 3'(i))) w_rdata = r_scratch[i];
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= '0;
      r_snap    <= '0;
      r_en      <= 1'b1;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      for (int i = 0; i < int'(NUM_SCRATCH); i++) r_scratch[i] <= '0;
    end else begin
      r_rvalid <= read;
      if (read) r_rdata <= w_rdata;
      if (read && (address == 4'd2)) r_snap <= r_counter[63:32];

      if (w_clr)     r_counter <= '0;
      else if (r_en) r_counter <= r_counter + 64'd1;
      if (w_ctrl_wr) r_en <= writedata[0];

      for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
        if (write && w_scr_hit && (address[2:0] == 3'(i))) begin
          for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) r_scratch[i][8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rvalid;

endmodule

// File: tb/tb_sysid_info_slave.sv
// Scoreboard bench for sysid_info_slave: the driver queues expected read data and
// latency, a negedge monitor checks every readdatavalid against the queue.
module tb_sysid_info_slave;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] q_data [$];
  int          q_cyc  [$];

  sysid_info_slave dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every valid must match the oldest queued read, one cycle after issue.
  always @(negedge clock) begin
    if (readdatavalid === 1'b1) begin
      if (q_data.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_valid: got valid with data 0x%08h, expected no valid", readdata);
      end else begin
        logic [31:0] e_data;
        int          e_cyc;
        e_data = q_data.pop_front();
        e_cyc  = q_cyc.pop_front();
        chk("read_data", readdata, e_data);
        chk("read_latency", 32'(cyc), 32'(e_cyc));
      end
    end
  end

  task automatic op(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] be, input logic [31:0] exp);
    @(negedge clock);
    read = r; write = w; address = a; writedata = d; byteenable = be;
    if (r) begin
      q_data.push_back(exp);
      q_cyc.push_back(cyc + 1);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    op(1'b1, 1'b0, a, 32'd0, 4'd0, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    op(1'b0, 1'b1, a, d, be, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    repeat (3) @(negedge clock);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_valid", {31'd0, readdatavalid}, 32'd0);
    reset_n = 1'b1;

    // ID registers, back-to-back reads
    rd(4'd0, 32'h0000_0007);
    rd(4'd1, 32'h5284_E192);
    rd(4'd0, 32'h0000_0007);

    // CTRL ignores writes without byteenable[0]; RO ignores writes
    wr(4'd4, 32'h0, 4'b1110);
    rd(4'd4, 32'h1);
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    rd(4'd0, 32'h0000_0007);

    // Scratch byte enables and reserved space
    wr(4'd8, 32'hAABB_CCDD, 4'hF);
    wr(4'd8, 32'h1122_3344, 4'b0101);
    rd(4'd8, 32'hAA22_CC44);
    rd(4'd12, 32'h0);
    rd(4'd5, 32'h0);
    wr(4'd15, 32'h5555_5555, 4'hF);
    rd(4'd15, 32'h0);
    wr(4'd11, 32'hDEAD_BEEF, 4'hF);
    rd(4'd11, 32'hDEAD_BEEF);

    // Read and write the same address: old value returned, new value lands
    op(1'b1, 1'b1, 4'd9, 32'hCAFE_F00D, 4'hF, 32'h0);
    rd(4'd9, 32'hCAFE_F00D);

    // CLR+EN, then stop: clear wins, then 0,1; disabling write still sees one increment
    wr(4'd4, 32'h3, 4'hF);
    rd(4'd2, 32'd0);
    rd(4'd2, 32'd1);
    wr(4'd4, 32'h0, 4'hF);
    idle(20);
    rd(4'd2, 32'd3);
    rd(4'd4, 32'd0);
    rd(4'd3, 32'd0);

    // Wrap: preload near the top with counting stopped, then enable
    idle(1);
    force dut.r_counter = 64'hFFFF_FFFF_FFFF_FFF0;
    @(negedge clock);
    release dut.r_counter;
    wr(4'd4, 32'h1, 4'h1);
    rd(4'd2, 32'hFFFF_FFF0);
    idle(20);
    rd(4'd3, 32'hFFFF_FFFF);
    rd(4'd2, 32'h0000_0006);
    rd(4'd3, 32'h0000_0000);

    // LO read followed by CLR: snapshot keeps pre-clear high word
    wr(4'd4, 32'h0, 4'h1);
    idle(1);
    force dut.r_counter = 64'h1234_5678_9ABC_DEF0;
    @(negedge clock);
    release dut.r_counter;
    rd(4'd2, 32'h9ABC_DEF0);
    op(1'b1, 1'b1, 4'd4, 32'h2, 4'h1, 32'h0);
    rd(4'd3, 32'h1234_5678);
    rd(4'd2, 32'h0);
    rd(4'd4, 32'h0);
    idle(2);

    // Reset right after a read edge aborts the pending valid
    @(negedge clock);
    read = 1'b1; write = 1'b0; address = 4'd1;
    @(posedge clock);
    #2 reset_n = 1'b0;
    read = 1'b0;
    @(negedge clock);
    chk("abort_valid", {31'd0, readdatavalid}, 32'd0);
    chk("abort_readdata", readdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    read = 1'b1; address = 4'd2;
    q_data.push_back(32'd0);
    q_cyc.push_back(cyc + 1);
    rd(4'd2, 32'd1);
    idle(2);
    rd(4'd8, 32'h0);
    rd(4'd11, 32'h0);
    rd(4'd9, 32'h0);
    rd(4'd4, 32'h1);
    rd(4'd3, 32'h0);
    idle(3);
    chk("queue_drained", 32'(q_data.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
